// File: rtl/onehot_reg_file.sv
// ----------------------------------------------------------------------------
// onehot_reg_file
//
// Eight-entry register file written through a one-hot select word coming from
// an upstream 3-to-8 decoder, with two independent registered read ports.
// Writes whose select word is not exactly one-hot are dropped and reported
// through a sticky flag and a saturating counter.
//
// Parameters
//   WIDTH    data width of every register and data port
//   ZERO_R0  1: register 0 is hard-wired to zero (writes accepted, discarded)
//            0: register 0 is an ordinary register
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   wr_en      write request
//   wr_sel     one-hot register select (bit k -> register k)
//   wr_data    write data
//   rd_addr_a  read port A binary address
//   rd_addr_b  read port B binary address
//   clr_err    clears sel_err and err_cnt
//   rd_data_a  registered read data, port A
//   rd_data_b  registered read data, port B
//   sel_err    sticky: a write was rejected for a malformed select
//   err_cnt    rejected-write count, saturating at 15
// ----------------------------------------------------------------------------
module onehot_reg_file #(
    parameter int WIDTH   = 16,
    parameter int ZERO_R0 = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [7:0]       wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [2:0]       rd_addr_a,
    input  logic [2:0]       rd_addr_b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             sel_err,
    output logic [3:0]       err_cnt
);

    logic [WIDTH-1:0] regs_reg [8];
    logic [WIDTH-1:0] rd_data_a_reg;
    logic [WIDTH-1:0] rd_data_b_reg;
    logic             sel_err_reg;
    logic [3:0]       err_cnt_reg;

    logic             sel_onehot;
    logic             wr_valid;
    logic             wr_malformed;
    logic [7:0]       wr_strobe;
    logic [WIDTH-1:0] rd_a_next;
    logic [WIDTH-1:0] rd_b_next;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign sel_onehot   = (wr_sel != 8'd0) && ((wr_sel & (wr_sel - 8'd1)) == 8'd0);
    assign wr_valid     = wr_en && sel_onehot;
    assign wr_malformed = wr_en && !sel_onehot;

    // Per-register write strobes. With a hard-wired r0 its strobe is tied off,
    // which also suppresses bypass for address 0 and keeps regs_reg[0] at zero.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_strobe
            if (gi == 0 && ZERO_R0 != 0) begin : g_zero
                assign wr_strobe[gi] = 1'b0;
            end else begin : g_normal
                assign wr_strobe[gi] = wr_valid & wr_sel[gi];
            end
        end
    endgenerate

    // Write-through bypass: a read of the register being written this cycle
    // returns the new data after the edge.
    always_comb begin
        rd_a_next = regs_reg[rd_addr_a];
        rd_b_next = regs_reg[rd_addr_b];
        if (wr_strobe[rd_addr_a]) begin
            rd_a_next = wr_data;
        end
        if (wr_strobe[rd_addr_b]) begin
            rd_b_next = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs_reg[i] <= '0;
            end
            rd_data_a_reg <= '0;
            rd_data_b_reg <= '0;
            sel_err_reg   <= 1'b0;
            err_cnt_reg   <= 4'd0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr_strobe[i]) begin
                    regs_reg[i] <= wr_data;
                end
            end
            rd_data_a_reg <= rd_a_next;
            rd_data_b_reg <= rd_b_next;

            // A malformed write in the same cycle as a clear wins: the count
            // restarts at one rather than zero.
            if (wr_malformed) begin
                sel_err_reg <= 1'b1;
                if (clr_err) begin
                    err_cnt_reg <= 4'd1;
                end else if (err_cnt_reg != 4'd15) begin
                    err_cnt_reg <= err_cnt_reg + 4'd1;
                end
            end else if (clr_err) begin
                sel_err_reg <= 1'b0;
                err_cnt_reg <= 4'd0;
            end
        end
    end

    assign rd_data_a = rd_data_a_reg;
    assign rd_data_b = rd_data_b_reg;
    assign sel_err   = sel_err_reg;
    assign err_cnt   = err_cnt_reg;

endmodule
